mul_fu_ctrl: RTL



---
 rtl/mul_fu_ctrl_if.sv | 31 +++
 rtl/mul_fu_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mul_fu_ctrl_if.sv
// Issue / multiplier / writeback signal bundle for the multiply functional-unit sequencer.
// The slave modport is the sequencer's view; the master modport is the scoreboard/multiplier side.
interface mul_fu_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 5
);
  logic               issue_valid;
  logic               issue_ready;
  logic [TAG_W-1:0]   issue_tag;
  logic [WIDTH-1:0]   issue_a;
  logic [WIDTH-1:0]   issue_b;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [2*WIDTH:0]   mul_out;
  logic               wb_req;
  logic               wb_grant;
  logic [TAG_W-1:0]   wb_tag;
  logic [2*WIDTH:0]   wb_data;
  logic               busy;
  logic               flush;

  modport master (
    output issue_valid, issue_tag, issue_a, issue_b, mul_out, wb_grant, flush,
    input  issue_ready, mul_a, mul_b, wb_req, wb_tag, wb_data, busy
  );

  modport slave (
    input  issue_valid, issue_tag, issue_a, issue_b, mul_out, wb_grant, flush,
    output issue_ready, mul_a, mul_b, wb_req, wb_tag, wb_data, busy
  );
endinterface

// File: rtl/mul_fu_ctrl.sv
// Multiply FU sequencer: holds operands on the multiplier for LATENCY cycles, then holds the product for writeback.
// Optional MUL_FU_BACK2BACK_EN lets a new issue be accepted in the same cycle as the writeback grant.
module mul_fu_ctrl #(
  parameter int WIDTH   = 16,
  parameter int TAG_W   = 5,
  parameter int LATENCY = 3
) (
  input logic          clk,
  input logic          rst,
  mul_fu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [3:0]         cnt_r;
  logic [WIDTH-1:0]   mul_a_r;
  logic [WIDTH-1:0]   mul_b_r;
  logic [TAG_W-1:0]   tag_r;
  logic [TAG_W-1:0]   wb_tag_r;
  logic [2*WIDTH:0]   wb_data_r;
  logic               wb_req_r;
  logic               busy_r;
  logic               issue_ready_r;

  // Control FSM with registered status outputs; flush outranks grant and issue
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= 4'd0;
      mul_a_r       <= '0;
      mul_b_r       <= '0;
      tag_r         <= '0;
      wb_tag_r      <= '0;
      wb_data_r     <= '0;
      wb_req_r      <= 1'b0;
      busy_r        <= 1'b0;
      issue_ready_r <= 1'b1;
    end else if (bus.flush) begin
      state_r       <= IDLE;
      wb_req_r      <= 1'b0;
      busy_r        <= 1'b0;
      issue_ready_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.issue_valid) begin
            mul_a_r       <= bus.issue_a;
            mul_b_r       <= bus.issue_b;
            tag_r         <= bus.issue_tag;
            cnt_r         <= 4'(LATENCY - 1);
            state_r       <= EXEC;
            busy_r        <= 1'b1;
            issue_ready_r <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            wb_data_r <= bus.mul_out;
            wb_tag_r  <= tag_r;
            wb_req_r  <= 1'b1;
            state_r   <= DONE;
          end
        end
        DONE: begin
          if (bus.wb_grant) begin
            wb_req_r <= 1'b0;
`ifdef MUL_FU_BACK2BACK_EN
            if (bus.issue_valid) begin
              mul_a_r <= bus.issue_a;
              mul_b_r <= bus.issue_b;
              tag_r   <= bus.issue_tag;
              cnt_r   <= 4'(LATENCY - 1);
              state_r <= EXEC;
            end else begin
              state_r       <= IDLE;
              busy_r        <= 1'b0;
              issue_ready_r <= 1'b1;
            end
`else
            state_r       <= IDLE;
            busy_r        <= 1'b0;
            issue_ready_r <= 1'b1;
`endif
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r       <= IDLE;
          wb_req_r      <= 1'b0;
          busy_r        <= 1'b0;
          issue_ready_r <= 1'b1;
        end
      endcase
    end
  end

`ifdef MUL_FU_BACK2BACK_EN
  // A grant frees the unit in the same cycle, so DONE may accept the next issue
  assign bus.issue_ready = issue_ready_r | ((state_r == DONE) & bus.wb_grant & ~bus.flush);
`else
  assign bus.issue_ready = issue_ready_r;
`endif

  assign bus.mul_a   = mul_a_r;
  assign bus.mul_b   = mul_b_r;
  assign bus.wb_req  = wb_req_r;
  assign bus.wb_tag  = wb_tag_r;
  assign bus.wb_data = wb_data_r;
  assign bus.busy    = busy_r;

endmodule
